// File: rtl/com_uart_rx_controller.sv
// com_uart_rx_controller: UART receiver with 2-flop input synchronisers,
// baud strobe edge detector, frame FSM (IDLE/START/DATA/PARITY/STOP) and a
// show-ahead receive FIFO with overrun detection.
// Optional build macro: COM_UART_RX_PARITY_EN enables the PARITY state and
// odd/even parity checking; without it parity_mode is ignored and
// parity_err is tied low.
module com_uart_rx_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_port,
    input  logic                  baudrate_clk,
    input  logic [1:0]            parity_mode,
    output logic                  stop_cond,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun_err,
    output logic                  fifo_full,
    output logic                  fifo_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t state_q, state_d;

    logic rx_s1_q, rx_s2_q, rx_prev_q;
    logic bd_s1_q, bd_s2_q, bd_prev_q;
    logic strobe, rx_fall;

    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]         cnt_q;
    logic                  push;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  pop, wr_en;

`ifdef COM_UART_RX_PARITY_EN
    logic par_on_q, par_odd_q, par_bad_q, par_exp;
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    // Input synchronisers; the third flop of each chain gives edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            bd_s1_q   <= 1'b0;
            bd_s2_q   <= 1'b0;
            bd_prev_q <= 1'b0;
        end else begin
            rx_s1_q   <= rx_port;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            bd_s1_q   <= baudrate_clk;
            bd_s2_q   <= bd_s1_q;
            bd_prev_q <= bd_s2_q;
        end
    end

    assign strobe  = bd_s2_q & ~bd_prev_q;
    assign rx_fall = rx_prev_q & ~rx_s2_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; strobes are ignored while idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (rx_fall) state_d = S_START;
            S_START:  if (strobe) state_d = rx_s2_q ? S_IDLE : S_DATA;
            S_DATA:   if (strobe && cnt_q == CW'(DATA_WIDTH - 1)) begin
`ifdef COM_UART_RX_PARITY_EN
                          state_d = par_on_q ? S_PARITY : S_STOP;
`else
                          state_d = S_STOP;
`endif
                      end
            S_PARITY: if (strobe) state_d = S_STOP;
            S_STOP:   if (strobe) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: stop pulse on false start or stop bit, error/push decisions at stop
    always_comb begin
        stop_cond  = strobe & ((state_q == S_STOP) | ((state_q == S_START) & rx_s2_q));
        frame_err  = strobe & (state_q == S_STOP) & ~rx_s2_q;
`ifdef COM_UART_RX_PARITY_EN
        parity_err = strobe & (state_q == S_STOP) & rx_s2_q & par_bad_q;
        push       = strobe & (state_q == S_STOP) & rx_s2_q & ~par_bad_q;
`else
        parity_err = 1'b0;
        push       = strobe & (state_q == S_STOP) & rx_s2_q;
`endif
    end

    // Shift register next value: LSB arrives first, so new bits enter at the MSB
    always_comb begin
        sh_d                 = sh_q >> 1;
        sh_d[DATA_WIDTH-1]   = rx_s2_q;
    end

`ifdef COM_UART_RX_PARITY_EN
    // Expected parity bit for the assembled word
    always_comb begin
        par_exp = par_odd_q ? ~(^sh_q) : (^sh_q);
    end
`endif

    // Frame datapath: bit counter, shift register and parity bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
`ifdef COM_UART_RX_PARITY_EN
            par_on_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: cnt_q <= '0;
                S_START: if (strobe) begin
                    cnt_q <= '0;
`ifdef COM_UART_RX_PARITY_EN
                    // parity mode is latched once per frame, on leaving START
                    par_on_q  <= (parity_mode == 2'b01) | (parity_mode == 2'b10);
                    par_odd_q <= (parity_mode == 2'b01);
                    par_bad_q <= 1'b0;
`endif
                end
                S_DATA: if (strobe) begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + 1'b1;
                end
`ifdef COM_UART_RX_PARITY_EN
                S_PARITY: if (strobe) par_bad_q <= (rx_s2_q != par_exp);
`endif
                default: ;
            endcase
        end
    end

    // FIFO control: a push into a full FIFO only succeeds when a pop frees a slot
    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == (AW+1)'(FIFO_DEPTH));
    assign data_valid  = ~fifo_empty;
    assign pop         = data_valid & data_ready;
    assign wr_en       = push & (~fifo_full | pop);
    assign overrun_err = push & fifo_full & ~pop;
    assign data_out    = fifo_empty ? '0 : mem_q[rd_ptr_q];

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= sh_q;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_com_uart_rx_controller.sv
// Bench for com_uart_rx_controller: directed vector table, hand-written
// corner sequences, and randomized frames checked against a frame-level model.
module tb_com_uart_rx_controller;
    localparam int W     = 8;
    localparam int DEPTH = 4;
`ifdef COM_UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_port = 1'b1;
    logic         baudrate_clk = 1'b0;
    logic [1:0]   parity_mode = 2'b00;
    logic         stop_cond;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready = 1'b0;
    logic         frame_err, parity_err, overrun_err;
    logic         fifo_full, fifo_empty;

    com_uart_rx_controller #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx_port(rx_port), .baudrate_clk(baudrate_clk),
        .parity_mode(parity_mode), .stop_cond(stop_cond), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready), .frame_err(frame_err),
        .parity_err(parity_err), .overrun_err(overrun_err),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_stop = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
    logic [W-1:0] popped[$];
    logic [W-1:0] exp_q[$];

    // Pulse counters and pop capture, sampled mid-cycle
    always @(negedge clk) begin
        if (stop_cond)   n_stop++;
        if (frame_err)   n_ferr++;
        if (parity_err)  n_perr++;
        if (overrun_err) n_ovr++;
        if (data_valid && data_ready) popped.push_back(data_out);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_bit(input logic b);
        rx_port = b;
        tick(3);
        baudrate_clk = 1'b1;
        tick(4);
        baudrate_clk = 1'b0;
        tick(5);
    endtask

    // Frame on the wire; parity bit appears only when the build and mode use it.
    // pm_late is applied after the start bit to show mid-frame changes are ignored.
    task automatic send_frame(input logic [W-1:0] d, input logic [1:0] pm, input logic pb,
                              input logic stop, input logic [1:0] pm_late);
        parity_mode = pm;
        send_bit(1'b0);
        parity_mode = pm_late;
        for (int i = 0; i < W; i++) send_bit(d[i]);
        if (PAR && (pm == 2'b01 || pm == 2'b10)) send_bit(pb);
        send_bit(stop);
        rx_port = 1'b1;
        tick(4);
    endtask

    // Frame-level reference: what the receiver should conclude about one frame
    function automatic void model(input logic [W-1:0] d, input logic [1:0] pm, input logic pb,
                                  input logic stop, output bit ferr, output bit perr, output bit good);
        bit act;
        int ones;
        bit pok;
        act  = PAR && (pm == 2'b01 || pm == 2'b10);
        ones = $countones(d) + int'(pb);
        pok  = (pm == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0);
        ferr = !stop;
        perr = stop && act && !pok;
        good = stop && !(act && !pok);
    endfunction

    // Pop everything, then compare the words that came out with those expected
    task automatic drain(input string name);
        int guard = 0;
        data_ready = 1'b1;
        while (!fifo_empty && guard < 4 * DEPTH + 8) begin tick(1); guard++; end
        data_ready = 1'b0;
        tick(1);
        chk({name, " drain done"}, int'(fifo_empty), 1);
        chk({name, " pop count"}, popped.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < popped.size(); i++)
            chk({name, " pop data"}, int'(popped[i]), int'(exp_q[i]));
        popped.delete();
        exp_q.delete();
    endtask

    // One frame checked against the model (also used for sequenced corner cases)
    task automatic model_frame(input string name, input logic [W-1:0] d, input logic [1:0] pm,
                               input logic pb, input logic stop, input logic [1:0] pm_late,
                               input logic rdy);
        int s0, f0, p0, o0, occ;
        bit ef, ep, eg, eovr;
        s0 = n_stop; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
        model(d, pm, pb, stop, ef, ep, eg);
        occ  = exp_q.size() - popped.size();
        eovr = eg && !rdy && occ == DEPTH;
        data_ready = rdy;
        send_frame(d, pm, pb, stop, pm_late);
        if (eg && !eovr) exp_q.push_back(d);
        chk({name, " stop_cond"}, n_stop - s0, 1);
        chk({name, " frame_err"}, n_ferr - f0, int'(ef));
        chk({name, " parity_err"}, n_perr - p0, int'(ep));
        chk({name, " overrun_err"}, n_ovr - o0, int'(eovr));
        if (!rdy) begin
            occ = exp_q.size() - popped.size();
            chk({name, " fifo_full"}, int'(fifo_full), int'(occ == DEPTH));
            chk({name, " fifo_empty"}, int'(fifo_empty), int'(occ == 0));
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   pm;
        logic         pb;
        logic         stop;
        logic         rdy;
        int           eferr;
        int           eperr;
        int           epush;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int s0, f0, p0;
        tbl[0] = '{8'hA5, 2'b00, 1'b0, 1'b1, 1'b1, 0, 0, 1};
        tbl[1] = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 1, 0, 0};
        tbl[2] = '{8'h07, 2'b10, 1'b0, 1'b1, 1'b0, 0, PAR ? 1 : 0, PAR ? 0 : 1};
        tbl[3] = '{8'h07, 2'b10, 1'b1, 1'b1, 1'b0, 0, 0, 1};
        tbl[4] = '{8'h07, 2'b01, 1'b0, 1'b1, 1'b1, 0, 0, 1};
        tbl[5] = '{8'hFF, 2'b01, 1'b0, 1'b1, 1'b0, 0, PAR ? 1 : 0, PAR ? 0 : 1};
        tbl[6] = '{8'h00, 2'b11, 1'b1, 1'b1, 1'b0, 0, 0, 1};
        tbl[7] = '{8'h3C, 2'b10, 1'b1, 1'b0, 1'b0, 1, 0, 0};

        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst data_valid", int'(data_valid), 0);
        chk("rst fifo_empty", int'(fifo_empty), 1);
        chk("rst fifo_full", int'(fifo_full), 0);
        chk("rst data_out", int'(data_out), 0);
        chk("rst pulses", int'({stop_cond, frame_err, parity_err, overrun_err}), 0);
        rst = 1'b0;
        tick(6);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            s0 = n_stop; f0 = n_ferr; p0 = n_perr;
            data_ready = tbl[i].rdy;
            send_frame(tbl[i].data, tbl[i].pm, tbl[i].pb, tbl[i].stop, tbl[i].pm);
            chk($sformatf("tbl%0d stop_cond", i), n_stop - s0, 1);
            chk($sformatf("tbl%0d frame_err", i), n_ferr - f0, tbl[i].eferr);
            chk($sformatf("tbl%0d parity_err", i), n_perr - p0, tbl[i].eperr);
            if (tbl[i].epush != 0) exp_q.push_back(tbl[i].data);
            drain($sformatf("tbl%0d", i));
        end

        // Glitch on rx: false start
        s0 = n_stop; f0 = n_ferr; p0 = n_perr;
        rx_port = 1'b0; tick(3); rx_port = 1'b1; tick(2);
        baudrate_clk = 1'b1; tick(4); baudrate_clk = 1'b0; tick(6);
        chk("glitch stop_cond", n_stop - s0, 1);
        chk("glitch errors", (n_ferr - f0) + (n_perr - p0), 0);
        chk("glitch fifo_empty", int'(fifo_empty), 1);
        send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 2'b00);
        exp_q.push_back(8'h5A);
        drain("after glitch");

        // Fill to full, overrun on fifth, pops in order
        for (int i = 1; i <= 5; i++)
            model_frame($sformatf("fill%0d", i), W'(i), 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
        drain("fill");

        // Push and pop in the same cycle while full is not an overrun
        for (int i = 0; i < DEPTH; i++)
            model_frame("pre", W'(8'h10 + i), 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
        model_frame("full+pop", 8'h20, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1);
        drain("full+pop");

        // Reset mid-DATA of 0x55, then a good 0x66
        s0 = n_stop;
        parity_mode = 2'b00;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rx_port = 1'b1;
        rst = 1'b1; tick(3);
        @(negedge clk);
        chk("midrst fifo_empty", int'(fifo_empty), 1);
        rst = 1'b0; tick(8);
        chk("midrst no stop", n_stop - s0, 0);
        model_frame("post rst", 8'h66, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
        drain("post rst");

        // Randomized frames against the model
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] d;
            logic [1:0] pm, pl;
            logic pb, st, rdy;
            d   = W'($urandom);
            pm  = 2'($urandom);
            pl  = 2'($urandom);
            pb  = 1'($urandom);
            st  = ($urandom_range(0, 5) != 0);
            rdy = ($urandom_range(0, 3) == 0);
            model_frame($sformatf("rnd%0d", i), d, pm, pb, st, pl, rdy);
            if ($urandom_range(0, 4) == 0) drain($sformatf("rnd%0d", i));
        end
        drain("rnd end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
